// File: rtl/sargantana_icache_refill_resp.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : sargantana_icache_refill_resp
// Icache miss responder: fetches one line as BEATS single-beat memory reads.
// Rev    : 1.0
// ============================================================================
module sargantana_icache_refill_resp #(
  parameter int PADDR_W = 40,
  parameter int LINE_W  = 128,
  parameter int BEAT_W  = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               ic_req_valid_i,
  output logic               ic_req_ready_o,
  input  logic [PADDR_W-1:0] ic_req_paddr_i,
  input  logic               ic_kill_i,
  output logic               ic_resp_valid_o,
  output logic [LINE_W-1:0]  ic_resp_data_o,
  output logic               ic_resp_error_o,
  output logic               mem_req_valid_o,
  input  logic               mem_req_ready_i,
  output logic [PADDR_W-1:0] mem_req_addr_o,
  input  logic               mem_rsp_valid_i,
  input  logic [BEAT_W-1:0]  mem_rsp_data_i,
  input  logic               mem_rsp_error_i
);

  localparam int c_BEATS    = LINE_W / BEAT_W;
  localparam int c_CNT_W    = $clog2(c_BEATS);
  localparam int c_LINE_OFF = $clog2(LINE_W / 8);
  localparam int c_BEAT_OFF = $clog2(BEAT_W / 8);
  localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(c_BEATS - 1);

  localparam logic [2:0] c_S_IDLE  = 3'd0;
  localparam logic [2:0] c_S_REQ   = 3'd1;
  localparam logic [2:0] c_S_WAIT  = 3'd2;
  localparam logic [2:0] c_S_DRAIN = 3'd3;
  localparam logic [2:0] c_S_RESP  = 3'd4;

  logic [2:0]                     r_state;
  logic [2:0]                     w_next;
  logic [PADDR_W-1:0]             r_base;
  logic [c_CNT_W-1:0]             r_cnt;
  logic [c_BEATS-1:0][BEAT_W-1:0] r_line;
  logic                           r_err;
  logic [LINE_W-1:0]              r_resp_data;
  logic                           r_resp_err;

  logic               w_accept;
  logic               w_beat;
  logic               w_last;
  logic [PADDR_W-1:0] w_offset;
  logic               w_unused_paddr_lo;

  assign w_accept = ic_req_valid_i && (r_state == c_S_IDLE);
  assign w_beat   = mem_rsp_valid_i && (r_state == c_S_WAIT);
  assign w_last   = (r_cnt == c_LAST);
  // Base is line aligned, so the beat offset never carries past the line.
  assign w_offset = PADDR_W'(r_cnt) << c_BEAT_OFF;
  assign w_unused_paddr_lo = ^ic_req_paddr_i[c_LINE_OFF-1:0];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= c_S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_S_IDLE: begin
        if (ic_req_valid_i) w_next = c_S_REQ;
      end
      c_S_REQ: begin
        if (mem_req_ready_i)  w_next = ic_kill_i ? c_S_DRAIN : c_S_WAIT;
        else if (ic_kill_i)   w_next = c_S_IDLE;
      end
      c_S_WAIT: begin
        if (mem_rsp_valid_i) begin
          if (ic_kill_i)   w_next = c_S_IDLE;
          else if (w_last) w_next = c_S_RESP;
          else             w_next = c_S_REQ;
        end else if (ic_kill_i) begin
          w_next = c_S_DRAIN;
        end
      end
      c_S_DRAIN: begin
        if (mem_rsp_valid_i) w_next = c_S_IDLE;
      end
      c_S_RESP: w_next = c_S_IDLE;
      default:  w_next = c_S_IDLE;
    endcase
  end

  always_comb begin
    ic_req_ready_o  = 1'b0;
    mem_req_valid_o = 1'b0;
    ic_resp_valid_o = 1'b0;
    case (r_state)
      c_S_IDLE: ic_req_ready_o  = 1'b1;
      c_S_REQ:  mem_req_valid_o = 1'b1;
      c_S_RESP: ic_resp_valid_o = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_base      <= '0;
      r_cnt       <= '0;
      r_line      <= '0;
      r_err       <= 1'b0;
      r_resp_data <= '0;
      r_resp_err  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_base <= {ic_req_paddr_i[PADDR_W-1:c_LINE_OFF], {c_LINE_OFF{1'b0}}};
        r_cnt  <= '0;
        r_err  <= 1'b0;
      end
      if (w_beat) begin
        r_line[r_cnt] <= mem_rsp_data_i;
        r_err         <= r_err | mem_rsp_error_i;
        if (!w_last) r_cnt <= r_cnt + c_CNT_W'(1);
        // Snapshot the finished line so the output holds until the next response.
        if (w_last && !ic_kill_i) begin
          r_resp_data <= {mem_rsp_data_i, r_line[c_BEATS-2:0]};
          r_resp_err  <= r_err | mem_rsp_error_i;
        end
      end
    end
  end

  assign mem_req_addr_o  = r_base + w_offset;
  assign ic_resp_data_o  = r_resp_data;
  assign ic_resp_error_o = r_resp_err;

endmodule
`default_nettype wire

// File: doc/sargantana_icache_refill_resp.md
Name: sargantana_icache_refill_resp

Overview:
- Responder for instruction-cache miss requests: accepts one line-refill request, fetches the line from the memory side as BEATS sequential single-beat reads, and returns the assembled line.
- Honours the icache kill semantics (KILL/KILL_TLB), so a killed refill completes its memory traffic silently and never produces a response.
- Sits between the icache controller's miss port and the L2/memory beat interface.

Parameters:
- PADDR_W, 40, physical address width.
- LINE_W, 128, cache line width in bits.
- BEAT_W, 32, memory beat width in bits. Constraints: LINE_W % BEAT_W == 0; BEATS = LINE_W/BEAT_W is a power of 2 and at least 2.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- ic_req_valid_i  in  1  miss request valid.
- ic_req_ready_o  out  1  responder idle, can accept a request.
- ic_req_paddr_i  in  PADDR_W  miss physical address (any byte within the line).
- ic_kill_i  in  1  icache abandons the outstanding refill.
- ic_resp_valid_o  out  1  one-cycle pulse: line valid.
- ic_resp_data_o  out  LINE_W  refilled line.
- ic_resp_error_o  out  1  at least one beat returned an error (qualified by ic_resp_valid_o).
- mem_req_valid_o  out  1  beat read request.
- mem_req_ready_i  in  1  memory accepts the request.
- mem_req_addr_o  out  PADDR_W  beat address.
- mem_rsp_valid_i  in  1  beat data valid.
- mem_rsp_data_i  in  BEAT_W  beat data.
- mem_rsp_error_i  in  1  beat error.

Behaviour:
- FSM states: IDLE, REQ, WAIT, DRAIN, RESP. Reset places the FSM in IDLE.
- Reset values: beat counter = 0, line buffer = 0, sticky error = 0, all outputs 0 except ic_req_ready_o = 1.
- A reset mid-operation abandons everything. Any mem_rsp_valid_i arriving after reset is ignored.
- IDLE:
  - ic_req_ready_o = (state == IDLE).
  - On valid && ready: latch base = paddr with the low log2(LINE_W/8) bits cleared; clear the counter and sticky error; go to REQ.
  - ic_kill_i is ignored in IDLE.
- REQ:
  - mem_req_valid_o = 1; mem_req_addr_o = base + counter*(BEAT_W/8).
  - Address arithmetic is PADDR_W wide and never carries out of the line.
  - Handshake (mem_req_ready_i = 1) -> WAIT, unless ic_kill_i is high in the same cycle, in which case -> DRAIN.
  - ic_kill_i without a handshake -> IDLE. Nothing is outstanding, so no request is issued.
- WAIT:
  - On mem_rsp_valid_i: write data to line[counter*BEAT_W +: BEAT_W] (beat 0 least significant); OR mem_rsp_error_i into the sticky error.
  - If counter == BEATS-1 -> RESP; otherwise counter+1 and -> REQ.
  - ic_kill_i in WAIT -> DRAIN. If mem_rsp_valid_i arrives in the same cycle, the beat is consumed and the FSM goes to IDLE instead.
- DRAIN:
  - Wait for the single outstanding beat, discard it, then -> IDLE.
  - mem_req_valid_o = 0; no response is produced.
- RESP:
  - ic_resp_valid_o = 1 for exactly one cycle; ic_resp_data_o = line buffer; ic_resp_error_o = sticky error; then -> IDLE.
  - ic_kill_i in RESP has no effect, because the response is already issued.
- ic_resp_data_o holds its last value between responses.
- At most one memory beat is outstanding at any time.
- mem_rsp_valid_i outside WAIT/DRAIN is ignored. The bench asserts it never occurs.
- An error beat does not shorten the refill: all BEATS beats are always fetched.
- Latency, with mem_req_ready_i tied high and a 1-cycle memory response:
  - Accept at cycle 0, ic_resp_valid_o at cycle 2*BEATS+1 (9 for the defaults).
  - ic_req_ready_o is back to 1 at cycle 2*BEATS+2.
- Outputs are driven from registers and state decode only; no input-to-output combinational path except none on the ic_* side.

Test Plan:
- Basic refill, defaults: paddr 0x80001234, ready tied 1, 1-cycle memory returning beat k = 0xA0+k.
  -> mem addrs 0x80001230, 0x80001234, 0x80001238, 0x8000123C.
  -> resp at cycle 9, data 0x000000A3_000000A2_000000A1_000000A0, error 0.
- Backpressure: mem_req_ready_i low for 3 cycles on each beat; response latency 5 cycles per beat.
  -> mem_req_addr_o stable while stalled; exactly 4 handshakes; same data as the basic refill.
- Kill in WAIT of beat 1: responder goes to DRAIN, consumes beat 1, returns to IDLE.
  -> No resp pulse; only 2 mem requests total; ready=1 the cycle after the drained beat.
- Kill in REQ with mem_req_ready_i low -> IDLE next cycle, zero handshakes for that beat.
  -> A new request at paddr 0x100 is then accepted and refilled correctly.
- Error on beat 2 only -> all 4 beats fetched; resp error=1.
  -> The following clean refill reports error=0, confirming the sticky error clears on accept.
- Reset asserted in WAIT of beat 2 while a stale mem_rsp_valid_i arrives the cycle after reset.
  -> All outputs 0 and ready=1; the stale beat is ignored and the next refill's data is uncorrupted.
